// File: rtl/beam_pkg.sv
// Shared constants, the queued event record and a width helper for the
// laser-harp beam conditioning block.
package beam_pkg;

  localparam int NUM_BEAMS_DEFAULT       = 8;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int FIFO_DEPTH_DEFAULT      = 8;

  // Index width that stays at least one bit wide for a single channel.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAM_W_DEFAULT = index_width(NUM_BEAMS_DEFAULT);

  typedef struct packed {
    logic [BEAM_W_DEFAULT-1:0] beam;
    logic                      on;
  } beam_event_t;

endpackage

// File: rtl/beam_event_fifo.sv
// Synchronous show-ahead FIFO for beam events; the head entry is visible
// whenever the queue is non-empty and reads as zero when empty.
module beam_event_fifo
  import beam_pkg::*;
#(
  parameter int  DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter type entry_t = beam_event_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  output logic   full,
  input  logic   pop,
  output entry_t head,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; only pointers and count
  // carry state, and the head is forced to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/beam_debouncer.sv
// Synchronizes and debounces the raw photodiode comparator levels and queues
// one break/restore event per accepted level change toward the note trigger.
module beam_debouncer
  import beam_pkg::*;
#(
  parameter int   NUM_BEAMS       = NUM_BEAMS_DEFAULT,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int   FIFO_DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter logic BROKEN_LEVEL    = 1'b0,
  localparam int  BEAM_W          = index_width(NUM_BEAMS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BEAMS-1:0] beam_raw,
  output logic [NUM_BEAMS-1:0] beam_clean,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [BEAM_W-1:0]    event_beam,
  output logic                 event_on,
  output logic                 event_overflow,
  input  logic                 overflow_clr
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  typedef struct packed {
    logic [BEAM_W-1:0] beam;
    logic              on;
  } event_t;

  logic [NUM_BEAMS-1:0] norm;
  logic [NUM_BEAMS-1:0] sync_meta;
  logic [NUM_BEAMS-1:0] sync_lvl;
  logic [NUM_BEAMS-1:0] differ;
  logic [NUM_BEAMS-1:0] toggle;
  logic [NUM_BEAMS-1:0] pending;
  logic [NUM_BEAMS-1:0] pend_on;
  logic [NUM_BEAMS-1:0] grant;
  logic [CNT_W-1:0]     cnt [NUM_BEAMS];
  logic [BEAM_W-1:0]    grant_idx;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 overflow_set;
  event_t               push_data;
  event_t               head;

  // After normalization a 1 always means the beam is broken.
  assign norm = beam_raw ^ {NUM_BEAMS{~BROKEN_LEVEL}};

  // NOTE: registers use non-blocking '<=' so every flop samples pre-edge
  // values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_lvl  <= '0;
    end else begin
      sync_meta <= norm;
      sync_lvl  <= sync_meta;
    end
  end

  assign differ = sync_lvl ^ beam_clean;

  always_comb begin
    toggle = '0;
    for (int i = 0; i < NUM_BEAMS; i++) begin
      toggle[i] = differ[i] && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beam_clean <= '0;
      for (int i = 0; i < NUM_BEAMS; i++) cnt[i] <= '0;
    end else begin
      beam_clean <= beam_clean ^ toggle;
      for (int i = 0; i < NUM_BEAMS; i++) begin
        cnt[i] <= (differ[i] && !toggle[i]) ? cnt[i] + CNT_W'(1) : '0;
      end
    end
  end

  // Fixed-priority arbiter: scanning downward leaves the lowest pending index.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' with every output given a
    // default first, so no latch is inferred on any path.
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_BEAMS - 1; i >= 0; i--) begin
      if (pending[i]) grant_idx = BEAM_W'(i);
    end
    push             = (|pending) && !fifo_full;
    grant[grant_idx] = push;
    push_data.beam   = grant_idx;
    push_data.on     = pend_on[grant_idx];
  end

  // A channel granted this cycle frees its slot, so its own toggle loses nothing.
  assign overflow_set = |(toggle & pending & ~grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending        <= '0;
      pend_on        <= '0;
      event_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | toggle;
      pend_on <= (pend_on & ~toggle) | (~beam_clean & toggle);
      if (overflow_set)      event_overflow <= 1'b1;
      else if (overflow_clr) event_overflow <= 1'b0;
    end
  end

  beam_event_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (event_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (event_valid && event_ready),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign event_valid = !fifo_empty;
  assign event_beam  = head.beam;
  assign event_on    = head.on;

endmodule

// File: tb/tb_beam_debouncer.sv
// Directed and randomized bench for beam_debouncer, checked every cycle
// against a queue-based behavioural model of the debounce and event rules.
module tb_beam_debouncer;

  localparam int NB    = 8;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int BW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] beam_raw = '1;
  logic          event_ready = 1'b0;
  logic          overflow_clr = 1'b0;
  logic [NB-1:0] beam_clean;
  logic          event_valid;
  logic [BW-1:0] event_beam;
  logic          event_on;
  logic          event_overflow;

  beam_debouncer #(
    .NUM_BEAMS       (NB),
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH),
    .BROKEN_LEVEL    (1'b0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .beam_raw       (beam_raw),
    .beam_clean     (beam_clean),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_beam     (event_beam),
    .event_on       (event_on),
    .event_overflow (event_overflow),
    .overflow_clr   (overflow_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: levels as bit vectors, run lengths as integers, the
  // queue as a list of (beam*2 + on) codes.
  logic [NB-1:0] m_s1, m_s2, m_clean, m_pend, m_pend_on;
  int            m_run [NB];
  int            m_q [$];
  bit            m_ovf;
  int            seen [$];

  task automatic model_step();
    bit do_pop;
    bit ovf_set;
    int g;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_pend = '0; m_pend_on = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_q.delete();
      m_ovf = 1'b0;
      return;
    end
    do_pop  = (m_q.size() != 0) && event_ready;
    ovf_set = 1'b0;
    g       = -1;
    if (m_q.size() < DEPTH) begin
      for (int i = 0; i < NB; i++) if (m_pend[i] && g < 0) g = i;
    end
    if (g >= 0) begin
      m_q.push_back(g * 2 + int'(m_pend_on[g]));
      m_pend[g] = 1'b0;
    end
    // A level is accepted after DEB consecutive clocks of disagreement.
    for (int i = 0; i < NB; i++) begin
      if (m_s2[i] != m_clean[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_clean[i]   = ~m_clean[i];
          m_run[i]     = 0;
          if (m_pend[i]) ovf_set = 1'b1;
          m_pend[i]    = 1'b1;
          m_pend_on[i] = m_clean[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (ovf_set)           m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    m_s2 = m_s1;
    m_s1 = ~beam_raw;
  endtask

  task automatic tick();
    int head;
    @(posedge clk);
    model_step();
    #1;
    head = (m_q.size() != 0) ? m_q[0] : 0;
    check("beam_clean", beam_clean, m_clean);
    check("event_valid", event_valid, m_q.size() != 0);
    check("event_head", {event_beam, event_on}, head);
    check("event_overflow", event_overflow, m_ovf);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    beam_raw     = '1;
    event_ready  = 1'b0;
    overflow_clr = 1'b0;
    ticks(2);
    reset = 1'b0;
  endtask

  // Records the head each cycle while valid (ready must already be high).
  task automatic drain(input int budget);
    int c;
    seen.delete();
    c = 0;
    while (event_valid && c < budget) begin
      seen.push_back({event_beam, event_on});
      tick();
      c++;
    end
    check("drain_done", event_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NB-1:0] tgt;

    do_reset();
    check("rst_clean", beam_clean, '0);
    check("rst_valid", event_valid, 1'b0);
    check("rst_head", {event_beam, event_on}, 0);
    check("rst_ovf", event_overflow, 1'b0);

    // Clean break of beam 3.
    event_ready = 1'b1;
    beam_raw[3] = 1'b0;
    ticks(5);
    check("break_pre", beam_clean[3], 1'b0);
    tick();
    check("break_clean", beam_clean[3], 1'b1);
    check("break_novalid", event_valid, 1'b0);
    tick();
    check("break_valid", event_valid, 1'b1);
    check("break_event", {event_beam, event_on}, {3'd3, 1'b1});
    tick();
    check("break_popped", event_valid, 1'b0);

    // Glitch rejection on beam 0, twice to show the count restarts.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      beam_raw[0] = 1'b0;
      ticks(3);
      beam_raw[0] = 1'b1;
      ticks(6);
      check("glitch_clean", beam_clean[0], 1'b0);
      check("glitch_noevent", event_valid, 1'b0);
    end

    // Simultaneous breaks on beams 5, 1, 7.
    do_reset();
    event_ready = 1'b1;
    beam_raw[5] = 1'b0; beam_raw[1] = 1'b0; beam_raw[7] = 1'b0;
    ticks(7);
    check("simul_ev0", {event_valid, event_beam, event_on}, {1'b1, 3'd1, 1'b1});
    tick();
    check("simul_ev1", {event_valid, event_beam, event_on}, {1'b1, 3'd5, 1'b1});
    tick();
    check("simul_ev2", {event_valid, event_beam, event_on}, {1'b1, 3'd7, 1'b1});
    tick();
    check("simul_empty", event_valid, 1'b0);

    // Back-pressure: six breaks with the consumer stalled.
    do_reset();
    beam_raw[5:0] = '0;
    ticks(14);
    check("bp_valid", event_valid, 1'b1);
    check("bp_head", {event_beam, event_on}, {3'd0, 1'b1});
    check("bp_ovf", event_overflow, 1'b0);
    event_ready = 1'b1;
    drain(20);
    check("bp_count", seen.size(), 6);
    for (int i = 0; i < 6; i++) check("bp_order", (i < seen.size()) ? seen[i] : -1, i * 2 + 1);

    // Overflow: full FIFO, beam 2 breaks then restores while still pending.
    do_reset();
    beam_raw[0] = 1'b0; beam_raw[1] = 1'b0; beam_raw[3] = 1'b0; beam_raw[4] = 1'b0;
    ticks(12);
    check("ovf_pre", event_overflow, 1'b0);
    beam_raw[2] = 1'b0;
    ticks(8);
    check("ovf_still0", event_overflow, 1'b0);
    beam_raw[2] = 1'b1;
    ticks(8);
    check("ovf_set", event_overflow, 1'b1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", event_overflow, 1'b0);
    event_ready = 1'b1;
    drain(20);
    check("ovf_count", seen.size(), 5);
    check("ovf_e0", (seen.size() > 0) ? seen[0] : -1, 1);
    check("ovf_e3", (seen.size() > 3) ? seen[3] : -1, 9);
    check("ovf_last", (seen.size() > 4) ? seen[4] : -1, 4);

    // Reset in the middle of a debounce, with the beam left broken.
    do_reset();
    event_ready = 1'b1;
    beam_raw[6] = 1'b0;
    ticks(4);
    reset = 1'b1;
    tick();
    check("mid_rst_clean", beam_clean, '0);
    check("mid_rst_valid", event_valid, 1'b0);
    check("mid_rst_head", {event_beam, event_on}, 0);
    reset = 1'b0;
    ticks(5);
    check("mid_rst_quiet", beam_clean[6], 1'b0);
    tick();
    check("mid_rst_rebreak", beam_clean[6], 1'b1);
    tick();
    check("mid_rst_event", {event_valid, event_beam, event_on}, {1'b1, 3'd6, 1'b1});

    // Randomized traffic with phases of heavy back-pressure.
    do_reset();
    tgt = '1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 7) == 0) tgt[b] = ~tgt[b];
      beam_raw     = tgt;
      event_ready  = ((c / 300) % 2 == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
      overflow_clr = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
